// File: rtl/comparison_pkg.sv
// Shared definitions for the comparison arbiter: operation codes, FSM states,
// datapath widths and the response timeout limit.
package comparison_pkg;
    localparam int OPND_W = 4;
    localparam int RES_W  = 8;

    localparam logic [1:0] OP_EQ  = 2'b00;
    localparam logic [1:0] OP_GT  = 2'b01;
    localparam logic [1:0] OP_LT  = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;
    // Counter value at which the final unacknowledged RESP edge fires.
    localparam logic [7:0] TIMEOUT_LAST  = TIMEOUT_LIMIT - 8'd1;

    typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

    typedef struct packed {
        logic [OPND_W-1:0] x;
        logic [OPND_W-1:0] y;
        logic [1:0]        op;
    } cmpReq_t;
endpackage

// File: rtl/comparison_datapath.sv
// 4-bit unsigned comparison datapath: equal, greater, less-than, max,
// zero-extended to the 8-bit result bus.
module comparison_datapath
    import comparison_pkg::*;
(
    input  cmpReq_t           req,
    output logic [RES_W-1:0]  result
);
    always_comb begin
        result = '0;
        case (req.op)
            OP_EQ:   result = {7'b0, req.x == req.y};
            OP_GT:   result = {7'b0, req.x > req.y};
            OP_LT:   result = {7'b0, req.x < req.y};
            default: result = {4'b0, (req.x > req.y) ? req.x : req.y};
        endcase
    end
endmodule

// File: rtl/rr_pick.sv
// Round-robin winner: first set request bit searching upward from ptr+1,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [PW-1:0]      winner,
    output logic               anyReq
);
    int idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        winner = '0;
        anyReq = 1'b0;
        idx    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                winner = idx[PW-1:0];
                anyReq = 1'b1;
            end
        end
    end
endmodule

// File: rtl/comparison_arbiter.sv
// Round-robin arbiter sharing one comparison datapath among NUM_REQ requesters.
// Define COMPARISON_ARB_TIMEOUT_EN to abort unacknowledged responses after 255 cycles.
module comparison_arbiter
    import comparison_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*4-1:0]    reqX,
    input  logic [NUM_REQ*4-1:0]    reqY,
    input  logic [NUM_REQ*2-1:0]    reqOp,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      respValid,
    output logic [RES_W-1:0]        respData,
    input  logic [NUM_REQ-1:0]      respAck,
    output logic                    busy,
    output logic                    timeoutErr
);
    localparam int PW = $clog2(NUM_REQ);

    state_t           state, nextState;
    logic [PW-1:0]    ptr, owner, winner;
    logic             anyReq, ownerAck, timeoutHit;
    cmpReq_t          pick, latched;
    logic [RES_W-1:0] dpResult;

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) uPick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .anyReq (anyReq)
    );

    comparison_datapath uDp (
        .req    (latched),
        .result (dpResult)
    );

    always_comb begin
        pick.x  = reqX[int'(winner)*OPND_W +: OPND_W];
        pick.y  = reqY[int'(winner)*OPND_W +: OPND_W];
        pick.op = reqOp[int'(winner)*2 +: 2];
    end

    assign ownerAck = respAck[owner];
    assign busy     = (state != IDLE);

`ifdef COMPARISON_ARB_TIMEOUT_EN
    logic [7:0] toCnt;

    assign timeoutHit = (state == RESP) && !ownerAck && (toCnt == TIMEOUT_LAST);

    // Counter restarts every time RESP is entered; the error flag is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toCnt      <= '0;
            timeoutErr <= 1'b0;
        end else begin
            toCnt <= (state == RESP) ? toCnt + 8'd1 : 8'd0;
            if (timeoutHit) timeoutErr <= 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign timeoutErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = COMPUTE;
            COMPUTE: nextState = RESP;
            RESP:    if (ownerAck || timeoutHit) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= PW'(NUM_REQ - 1);
            owner     <= '0;
            latched   <= '0;
            grant     <= '0;
            respValid <= '0;
            respData  <= '0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: if (anyReq) begin
                    latched       <= pick;
                    owner         <= winner;
                    grant[winner] <= 1'b1;
                end
                COMPUTE: begin
                    respData         <= dpResult;
                    respValid[owner] <= 1'b1;
                end
                RESP: if (ownerAck || timeoutHit) begin
                    respValid <= '0;
                    ptr       <= owner;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_comparison_arbiter.sv
// Directed plus randomized bench for comparison_arbiter against a round-robin
// reference model kept in plain arithmetic.
module tb_comparison_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] reqX, reqY;
    logic [7:0]  reqOp;
    logic [3:0]  grant, respValid, respAck;
    logic [7:0]  respData;
    logic        busy, timeoutErr;

    logic [3:0]  mx [4];
    logic [3:0]  my [4];
    logic [1:0]  mop [4];
    int          mPtr;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    always_comb begin
        reqX = '0; reqY = '0; reqOp = '0;
        for (int i = 0; i < 4; i++) begin
            reqX[4*i +: 4]  = mx[i];
            reqY[4*i +: 4]  = my[i];
            reqOp[2*i +: 2] = mop[i];
        end
    end

    comparison_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .reqX(reqX), .reqY(reqY), .reqOp(reqOp),
        .grant(grant), .respValid(respValid), .respData(respData), .respAck(respAck),
        .busy(busy), .timeoutErr(timeoutErr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rrWin(input logic [3:0] m, input int p);
        for (int k = 1; k <= 4; k++)
            if (m[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [7:0] refCmp(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op);
        case (op)
            2'd0:    return (x == y) ? 8'd1 : 8'd0;
            2'd1:    return (x > y) ? 8'd1 : 8'd0;
            2'd2:    return (x < y) ? 8'd1 : 8'd0;
            default: return {4'h0, (x > y) ? x : y};
        endcase
    endfunction

    task automatic setOps(input int i, input logic [3:0] x, input logic [3:0] y, input logic [1:0] op);
        mx[i] = x; my[i] = y; mop[i] = op;
    endtask

    // Called at a negedge with the FSM in IDLE and req non-zero.
    task automatic doTxn(input int ackDelay, input bit dropReq, input bit changeOps, input bit forceOthers);
        int w;
        logic [7:0] e;
        w = rrWin(req, mPtr);
        @(negedge clk);
        check("grant", grant, 32'(1 << w));
        check("busyGrant", busy, 1);
        check("validAtGrant", respValid, 0);
        e = refCmp(mx[w], my[w], mop[w]);
        if (dropReq) req[w] = 1'b0;
        if (changeOps) setOps(w, 4'($urandom), 4'($urandom), 2'($urandom));
        @(negedge clk);
        check("grantPulse", grant, 0);
        check("respValid", respValid, 32'(1 << w));
        check("respData", respData, e);
        for (int d = 0; d < ackDelay; d++) begin
            respAck = (forceOthers && d == 0) ? ~4'(1 << w) : (4'($urandom) & ~4'(1 << w));
            @(negedge clk);
            check("validHeld", respValid, 32'(1 << w));
            check("dataHeld", respData, e);
        end
        respAck = 4'(1 << w);
        @(negedge clk);
        respAck = '0;
        check("validCleared", respValid, 0);
        check("idleAfterAck", busy, 0);
        mPtr = w;
    endtask

    initial begin
        logic [7:0] e;
        rst_n = 1'b0; req = 4'hF; respAck = '0;
        for (int i = 0; i < 4; i++) setOps(i, 4'($urandom), 4'($urandom), 2'($urandom));
        mPtr = 3;
        #12;
        check("rstGrant", grant, 0);
        check("rstValid", respValid, 0);
        check("rstData", respData, 0);
        check("rstBusy", busy, 0);
        check("rstTimeout", timeoutErr, 0);
        @(negedge clk); rst_n = 1'b1;

        // Contention: all requests held, same-cycle acks -> 0,1,2,3,0
        for (int t = 0; t < 5; t++) doTxn(0, 1'b0, 1'b0, 1'b0);
        req = '0;
        @(negedge clk);

        // Single request, x>y
        setOps(0, 4'd5, 4'd3, 2'b01); req = 4'b0001;
        doTxn(2, 1'b1, 1'b0, 1'b0);

        // Max, operands changed after the latch edge
        setOps(2, 4'h9, 4'hC, 2'b11); req = 4'b0100;
        doTxn(1, 1'b1, 1'b1, 1'b0);

        // Non-owner acks while owner is 3
        setOps(3, 4'h7, 4'h7, 2'b00); req = 4'b1000;
        doTxn(3, 1'b1, 1'b0, 1'b1);

        // Reset mid-RESP
        setOps(2, 4'h2, 4'hA, 2'b10); req = 4'b0100;
        @(negedge clk);
        check("grant2", grant, 4'b0100);
        req = '0;
        @(negedge clk);
        check("valid2", respValid, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("asyncGrant", grant, 0);
        check("asyncValid", respValid, 0);
        check("asyncData", respData, 0);
        check("asyncBusy", busy, 0);
        @(negedge clk); rst_n = 1'b1; mPtr = 3;
        setOps(0, 4'h1, 4'h4, 2'b11); setOps(2, 4'hF, 4'h0, 2'b01);
        req = 4'b0101;
        doTxn(0, 1'b1, 1'b0, 1'b0);
        doTxn(0, 1'b1, 1'b0, 1'b0);

        // Withheld acknowledge
        setOps(1, 4'h6, 4'h3, 2'b11); req = 4'b0010;
        e = refCmp(4'h6, 4'h3, 2'b11);
        @(negedge clk);
        check("grantTo", grant, 4'b0010);
        req = '0;
        @(negedge clk);
        check("validTo", respValid, 4'b0010);
`ifdef COMPARISON_ARB_TIMEOUT_EN
        repeat (254) @(negedge clk);
        check("validBeforeTo", respValid, 4'b0010);
        check("noErrBeforeTo", timeoutErr, 0);
        @(negedge clk);
        check("validAfterTo", respValid, 0);
        check("errAfterTo", timeoutErr, 1);
        check("idleAfterTo", busy, 0);
        mPtr = 1;
`else
        repeat (300) @(negedge clk);
        check("validNoTo", respValid, 4'b0010);
        check("dataNoTo", respData, e);
        check("noTimeoutErr", timeoutErr, 0);
        respAck = 4'b0010;
        @(negedge clk);
        respAck = '0;
        check("validLateAck", respValid, 0);
        mPtr = 1;
`endif
        setOps(3, 4'h2, 4'h9, 2'b01); req = 4'b1000;
        doTxn(1, 1'b1, 1'b0, 1'b0);
`ifdef COMPARISON_ARB_TIMEOUT_EN
        check("errSticky", timeoutErr, 1);
`else
        check("errTied", timeoutErr, 0);
`endif

        // Randomized traffic with rotating pointer model
        for (int t = 0; t < 40; t++) begin
            logic [3:0] add;
            add = 4'($urandom);
            if ((req | add) == 4'b0) add = 4'(1 << $urandom_range(0, 3));
            for (int i = 0; i < 4; i++)
                if (add[i] && !req[i]) begin
                    setOps(i, 4'($urandom), 4'($urandom), 2'($urandom));
                    req[i] = 1'b1;
                end
            doTxn($urandom_range(0, 3), 1'b1, 1'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
